// File: rtl/alu_exec_stage_pkg.sv
// Shared constants for the ALU execute stage: opcodes, element widths and the
// per-lane ALU operation used by the alu sub-module.
package alu_exec_stage_pkg;

   localparam int ALU_DW     = 64;
   localparam int ALU_TAG_W  = 5;
   localparam int ALU_MAX_OP = 18;

   // Opcodes; anything above ALU_MAX_OP is illegal.
   localparam logic [5:0] VAND  = 6'd0;
   localparam logic [5:0] VOR   = 6'd1;
   localparam logic [5:0] VXOR  = 6'd2;
   localparam logic [5:0] VNOT  = 6'd3;
   localparam logic [5:0] VMOV  = 6'd4;
   localparam logic [5:0] VADD  = 6'd5;
   localparam logic [5:0] VSUB  = 6'd6;
   localparam logic [5:0] VSLL  = 6'd7;
   localparam logic [5:0] VSRL  = 6'd8;
   localparam logic [5:0] VSRA  = 6'd9;
   localparam logic [5:0] VMINU = 6'd10;
   localparam logic [5:0] VMAXU = 6'd11;
   localparam logic [5:0] VCEQ  = 6'd12;
   localparam logic [5:0] VCGTU = 6'd13;
   localparam logic [5:0] VNEG  = 6'd14;
   localparam logic [5:0] VABS  = 6'd15;
   localparam logic [5:0] VROTL = 6'd16;
   localparam logic [5:0] VAVGU = 6'd17;
   localparam logic [5:0] VANDN = 6'd18;

   // Element width encodings carried on ww.
   typedef enum logic [1:0] {
      WW_8  = 2'd0,
      WW_16 = 2'd1,
      WW_32 = 2'd2,
      WW_64 = 2'd3
   } ww_e;

   // One lane of width w (8/16/32/64). Operands arrive zero-extended; the
   // result is masked back to w bits. Shift amounts wrap modulo the lane width.
   function automatic logic [63:0] lane_op(input logic [63:0] a, input logic [63:0] b,
                                           input logic [4:0] sh, input logic [5:0] op,
                                           input int unsigned w);
      logic [63:0] m;
      logic [63:0] sa;
      logic [63:0] r;
      logic [64:0] sum;
      int unsigned s;
      m   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      s   = 32'(sh) & (w - 1);
      sa  = (((a >> (w - 1)) & 64'd1) != 64'd0) ? (a | ~m) : a;
      sum = {1'b0, a} + {1'b0, b};
      case (op)
         VAND:    r = a & b;
         VOR:     r = a | b;
         VXOR:    r = a ^ b;
         VNOT:    r = ~a;
         VMOV:    r = a;
         VADD:    r = a + b;
         VSUB:    r = a - b;
         VSLL:    r = a << s;
         VSRL:    r = a >> s;
         VSRA:    r = $signed(sa) >>> s;
         VMINU:   r = (a < b) ? a : b;
         VMAXU:   r = (a > b) ? a : b;
         VCEQ:    r = (a == b) ? m : '0;
         VCGTU:   r = (a > b) ? m : '0;
         VNEG:    r = -a;
         VABS:    r = sa[63] ? -sa : sa;
         VROTL:   r = (a << s) | (a >> (w - s));
         VAVGU:   r = sum[64:1];
         VANDN:   r = a & ~b;
         default: r = '0;
      endcase
      return r & m;
   endfunction

endpackage

// File: rtl/alu_exec_stage_alu.sv
// Combinational lane-parallel ALU. Operand bit 0 in the MSB-first numbering is
// bit DW-1 here, so numeric values are identical. One result per element
// width is built lane by lane, then ww selects among them.
module alu
   import alu_exec_stage_pkg::*;
#(
   parameter int DW = ALU_DW
) (
   input  logic [DW-1:0] opra,
   input  logic [DW-1:0] oprb,
   input  logic [4:0]    shift_amount,
   input  logic [5:0]    op,
   input  logic [1:0]    ww,
   output logic [DW-1:0] result
);

   logic [3:0][DW-1:0] res_w;

   for (genvar gi = 0; gi < 4; gi++) begin : g_width
      localparam int unsigned LW = 8 << gi;
      for (genvar li = 0; li < DW / LW; li++) begin : g_lane
         logic [63:0] lane_res;
         assign lane_res = lane_op(64'(opra[li*LW +: LW]), 64'(oprb[li*LW +: LW]),
                                   shift_amount, op, LW);
         assign res_w[gi][li*LW +: LW] = lane_res[LW-1:0];
      end
   end

   assign result = res_w[ww];

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: one E register holding the accepted request, the alu fed only
// from E, and a 2-entry result buffer returning {result, tag, err}.
module alu_exec_stage
   import alu_exec_stage_pkg::*;
#(
   parameter int DW     = ALU_DW,
   parameter int TAG_W  = ALU_TAG_W,
   parameter int MAX_OP = ALU_MAX_OP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [DW-1:0]    req_oprA,
   input  logic [DW-1:0]    req_oprB,
   input  logic [4:0]       req_shift,
   input  logic [5:0]       req_op,
   input  logic [1:0]       req_ww,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DW-1:0]    rsp_result,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_err,
   output logic [1:0]       inflight
);

   localparam logic [5:0] MAX_OP_L = 6'(MAX_OP);

   // E register
   logic             e_valid_q, e_valid_d;
   logic [DW-1:0]    e_opra_q, e_opra_d;
   logic [DW-1:0]    e_oprb_q, e_oprb_d;
   logic [4:0]       e_shift_q, e_shift_d;
   logic [5:0]       e_op_q, e_op_d;
   logic [1:0]       e_ww_q, e_ww_d;
   logic [TAG_W-1:0] e_tag_q, e_tag_d;

   // Result buffer
   logic [DW-1:0]    buf_result_q [2];
   logic [DW-1:0]    buf_result_d [2];
   logic [TAG_W-1:0] buf_tag_q [2];
   logic [TAG_W-1:0] buf_tag_d [2];
   logic             buf_err_q [2];
   logic             buf_err_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   logic             buf_full, buf_empty;
   logic             accept, move, pop, e_illegal;
   logic [DW-1:0]    alu_result;

   alu #(.DW(DW)) u_alu (
      .opra         (e_opra_q),
      .oprb         (e_oprb_q),
      .shift_amount (e_shift_q),
      .op           (e_op_q),
      .ww           (e_ww_q),
      .result       (alu_result)
   );

   assign buf_full   = (count_q == 2'd2);
   assign buf_empty  = (count_q == 2'd0);
   assign req_ready  = !e_valid_q || !buf_full;
   assign rsp_valid  = !buf_empty;
   assign rsp_result = buf_result_q[rd_ptr_q];
   assign rsp_tag    = buf_tag_q[rd_ptr_q];
   assign rsp_err    = buf_err_q[rd_ptr_q];
   assign inflight   = {1'b0, e_valid_q} + count_q;

   assign accept    = req_valid && req_ready;
   assign pop       = rsp_valid && rsp_ready;
   // A pop in the same edge frees a slot, so a full buffer can still take E.
   assign move      = e_valid_q && (!buf_full || pop);
   assign e_illegal = (e_op_q > MAX_OP_L);

   // Next-state for E, buffer contents, pointers and occupancy
   always_comb begin
      e_valid_d    = e_valid_q;
      e_opra_d     = e_opra_q;
      e_oprb_d     = e_oprb_q;
      e_shift_d    = e_shift_q;
      e_op_d       = e_op_q;
      e_ww_d       = e_ww_q;
      e_tag_d      = e_tag_q;
      buf_result_d = buf_result_q;
      buf_tag_d    = buf_tag_q;
      buf_err_d    = buf_err_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q + {1'b0, move} - {1'b0, pop};

      if (move) begin
         buf_result_d[wr_ptr_q] = e_illegal ? '0 : alu_result;
         buf_tag_d[wr_ptr_q]    = e_tag_q;
         buf_err_d[wr_ptr_q]    = e_illegal;
         wr_ptr_d               = !wr_ptr_q;
         e_valid_d              = 1'b0;
      end
      if (pop) begin
         rd_ptr_d = !rd_ptr_q;
      end
      if (accept) begin
         e_valid_d = 1'b1;
         e_opra_d  = req_oprA;
         e_oprb_d  = req_oprB;
         e_shift_d = req_shift;
         e_op_d    = req_op;
         e_ww_d    = req_ww;
         e_tag_d   = req_tag;
      end
   end

   // State registers; reset discards all in-flight work immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_valid_q    <= 1'b0;
         e_opra_q     <= '0;
         e_oprb_q     <= '0;
         e_shift_q    <= '0;
         e_op_q       <= '0;
         e_ww_q       <= '0;
         e_tag_q      <= '0;
         buf_result_q <= '{default: '0};
         buf_tag_q    <= '{default: '0};
         buf_err_q    <= '{default: 1'b0};
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         count_q      <= 2'd0;
      end else begin
         e_valid_q    <= e_valid_d;
         e_opra_q     <= e_opra_d;
         e_oprb_q     <= e_oprb_d;
         e_shift_q    <= e_shift_d;
         e_op_q       <= e_op_d;
         e_ww_q       <= e_ww_d;
         e_tag_q      <= e_tag_d;
         buf_result_q <= buf_result_d;
         buf_tag_q    <= buf_tag_d;
         buf_err_q    <= buf_err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: reset/latency, lane spot values,
// streaming against a reference ALU model, back-pressure, illegal op and
// full-buffer push/pop.
module tb_alu_exec_stage;
   import alu_exec_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [63:0] req_oprA = '0;
   logic [63:0] req_oprB = '0;
   logic [4:0]  req_shift = '0;
   logic [5:0]  req_op = '0;
   logic [1:0]  req_ww = '0;
   logic [4:0]  req_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic [4:0]  rsp_tag;
   logic        rsp_err;
   logic [1:0]  inflight;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_exec_stage dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_oprA   (req_oprA),
      .req_oprB   (req_oprB),
      .req_shift  (req_shift),
      .req_op     (req_op),
      .req_ww     (req_ww),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .inflight   (inflight)
   );

   always #5 clk = ~clk;

   // Reference ALU: loops over lanes with shift/mask extraction.
   function automatic logic [63:0] model_alu(input logic [63:0] a, input logic [63:0] b,
                                             input logic [4:0] sh, input logic [5:0] op,
                                             input logic [1:0] ww);
      int w, n, s;
      logic [63:0] m, la, lb, lr, r;
      logic signed [63:0] sa;
      logic [64:0] sum;
      w = 8 << ww;
      n = 64 / w;
      s = int'(sh) % w;
      m = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      r = '0;
      for (int i = 0; i < n; i++) begin
         la  = (a >> (i * w)) & m;
         lb  = (b >> (i * w)) & m;
         sa  = (((la >> (w - 1)) & 64'd1) != 64'd0) ? $signed(la | ~m) : $signed(la);
         sum = {1'b0, la} + {1'b0, lb};
         case (op)
            VAND:    lr = la & lb;
            VOR:     lr = la | lb;
            VXOR:    lr = la ^ lb;
            VNOT:    lr = ~la;
            VMOV:    lr = la;
            VADD:    lr = la + lb;
            VSUB:    lr = la - lb;
            VSLL:    lr = la << s;
            VSRL:    lr = la >> s;
            VSRA:    lr = sa >>> s;
            VMINU:   lr = (la < lb) ? la : lb;
            VMAXU:   lr = (la > lb) ? la : lb;
            VCEQ:    lr = (la == lb) ? m : 64'd0;
            VCGTU:   lr = (la > lb) ? m : 64'd0;
            VNEG:    lr = 64'd0 - la;
            VABS:    lr = (sa < 0) ? -sa : sa;
            VROTL:   lr = (la << s) | (la >> (w - s));
            VAVGU:   lr = sum[64:1];
            VANDN:   lr = la & ~lb;
            default: lr = 64'd0;
         endcase
         r = r | ((lr & m) << (i * w));
      end
      return r;
   endfunction

   // Issue one request with rsp_ready=1 on an idle stage and capture its response.
   task automatic issue_and_wait(input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] sh, input logic [5:0] op,
                                 input logic [1:0] ww, input logic [4:0] tag,
                                 output logic got, output logic [63:0] res,
                                 output logic [4:0] rtag, output logic rerr);
      got = 1'b0; res = '0; rtag = '0; rerr = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      req_oprA = a; req_oprB = b; req_shift = sh; req_op = op; req_ww = ww; req_tag = tag;
      req_valid = 1'b1;
      for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid) begin
            got = 1'b1; res = rsp_result; rtag = rsp_tag; rerr = rsp_err;
            break;
         end
         @(negedge clk);
      end
      $display("txn tag=%0d op=%0d ww=%0d result=%h err=%b", rtag, op, ww, res, rerr);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rsp_ready = 1'b0;
      @(negedge clk);
      req_oprA = 64'h1; req_oprB = 64'h2; req_op = VADD; req_ww = 2'd3; req_tag = 5'd1;
      req_valid = 1'b1;
      @(negedge clk);
      req_tag = 5'd2;
      @(negedge clk);
      req_valid = 1'b0;
      total_cnt++;
      if (inflight !== 2'd2) $display("FAIL pre_reset_inflight: got %0d expected 2", inflight);
      else pass_cnt++;
      #2 reset = 1'b0;
      #1;
      total_cnt++;
      if (inflight !== 2'd0 || rsp_valid !== 1'b0)
         $display("FAIL async_reset: inflight %0d rsp_valid %b expected 0 0", inflight, rsp_valid);
      else pass_cnt++;
      @(negedge clk);
      reset = 1'b1;
      #1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready);
      else pass_cnt++;
      total_cnt++;
      if (rsp_valid !== 1'b0 || inflight !== 2'd0)
         $display("FAIL reset_state: rsp_valid %b inflight %0d expected 0 0", rsp_valid, inflight);
      else pass_cnt++;
      total_cnt++;
      if (rsp_result !== 64'd0 || rsp_tag !== 5'd0 || rsp_err !== 1'b0)
         $display("FAIL reset_fields: result %h tag %0d err %b expected 0 0 0", rsp_result, rsp_tag, rsp_err);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b0) $display("FAIL no_partial_after_reset: got %b expected 0", rsp_valid);
      else pass_cnt++;
   endtask

   task automatic test_accept_latency();
      @(negedge clk);
      req_oprA = 64'h8080808080808080; req_oprB = 64'h0101010101010101;
      req_shift = 5'd0; req_op = VOR; req_ww = 2'd3; req_tag = 5'd5;
      req_valid = 1'b1; rsp_ready = 1'b1;
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL accept_ready: got %b expected 1", req_ready);
      else pass_cnt++;
      @(negedge clk);
      req_valid = 1'b0;
      total_cnt++;
      if (rsp_valid !== 1'b0 || inflight !== 2'd1)
         $display("FAIL latency_edge1: rsp_valid %b inflight %0d expected 0 1", rsp_valid, inflight);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_result !== 64'h8181818181818181 || rsp_tag !== 5'd5 || rsp_err !== 1'b0)
         $display("FAIL latency_edge2: valid %b result %h tag %0d err %b expected 1 8181818181818181 5 0",
                  rsp_valid, rsp_result, rsp_tag, rsp_err);
      else pass_cnt++;
      $display("txn tag=%0d result=%h err=%b", rsp_tag, rsp_result, rsp_err);
      @(negedge clk);
      total_cnt++;
      if (rsp_valid !== 1'b0 || inflight !== 2'd0)
         $display("FAIL after_pop: rsp_valid %b inflight %0d expected 0 0", rsp_valid, inflight);
      else pass_cnt++;
   endtask

   task automatic test_lanes();
      logic got, err;
      logic [63:0] res;
      logic [4:0] tag;
      logic [63:0] exp_res [5];
      logic [63:0] va [5];
      logic [63:0] vb [5];
      logic [5:0]  vop [5];
      logic [1:0]  vww [5];
      logic [4:0]  vsh [5];
      va[0] = 64'h00FF00FF00FF00FF; vb[0] = 64'h0001000100010001; vop[0] = VADD;  vww[0] = 2'd0; vsh[0] = 5'd0;
      exp_res[0] = 64'h0000000000000000;
      va[1] = 64'h00FF00FF00FF00FF; vb[1] = 64'h0001000100010001; vop[1] = VADD;  vww[1] = 2'd1; vsh[1] = 5'd0;
      exp_res[1] = 64'h0100010001000100;
      va[2] = 64'h0;                vb[2] = 64'h1;                vop[2] = VSUB;  vww[2] = 2'd3; vsh[2] = 5'd0;
      exp_res[2] = 64'hFFFFFFFFFFFFFFFF;
      va[3] = 64'h8000000000000010; vb[3] = 64'h0;                vop[3] = VSRA;  vww[3] = 2'd2; vsh[3] = 5'd4;
      exp_res[3] = 64'hF800000000000001;
      va[4] = 64'h8100000000000080; vb[4] = 64'h0;                vop[4] = VROTL; vww[4] = 2'd0; vsh[4] = 5'd9;
      exp_res[4] = 64'h0300000000000001;
      for (int i = 0; i < 5; i++) begin
         issue_and_wait(va[i], vb[i], vsh[i], vop[i], vww[i], 5'(20 + i), got, res, tag, err);
         total_cnt++;
         if (got !== 1'b1 || res !== exp_res[i] || tag !== 5'(20 + i) || err !== 1'b0)
            $display("FAIL lane_%0d: got valid %b result %h tag %0d err %b expected 1 %h %0d 0",
                     i, got, res, tag, err, exp_res[i], 20 + i);
         else pass_cnt++;
      end
   endtask

   task automatic test_streaming();
      logic [63:0] exp_q [$];
      logic [4:0]  exp_tag_q [$];
      int sent = 0;
      int recv = 0;
      logic [63:0] a, b;
      logic [5:0] op;
      logic [1:0] ww;
      logic [4:0] sh;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && recv < 38; cyc++) begin
         @(negedge clk);
         if (rsp_valid) begin
            total_cnt++;
            if (exp_q.size() == 0 || rsp_result !== exp_q[0] || rsp_tag !== exp_tag_q[0] || rsp_err !== 1'b0)
               $display("FAIL stream_result_%0d: result %h tag %0d err %b expected %h %0d 0", recv,
                        rsp_result, rsp_tag, rsp_err,
                        (exp_q.size() != 0) ? exp_q[0] : 64'd0,
                        (exp_tag_q.size() != 0) ? exp_tag_q[0] : 5'd0);
            else pass_cnt++;
            $display("stream tag=%0d result=%h", rsp_tag, rsp_result);
            if (exp_q.size() != 0) begin
               void'(exp_q.pop_front());
               void'(exp_tag_q.pop_front());
            end
            recv++;
         end
         if (sent < 38) begin
            a  = 64'h8123456789ABCDEF ^ (64'(sent) * 64'h0101010101010101);
            b  = 64'h0F0FF0F012348765 + (64'(sent) * 64'h0011000022000033);
            op = 6'(sent % 19);
            ww = (sent < 19) ? 2'd3 : 2'd2;
            sh = 5'(sent + 3);
            req_oprA = a; req_oprB = b; req_op = op; req_ww = ww; req_shift = sh;
            req_tag = 5'(sent);
            req_valid = 1'b1;
            total_cnt++;
            if (req_ready !== 1'b1) $display("FAIL stream_ready_%0d: got %b expected 1", sent, req_ready);
            else pass_cnt++;
            if (req_ready) begin
               exp_q.push_back(model_alu(a, b, sh, op, ww));
               exp_tag_q.push_back(5'(sent));
               sent++;
            end
         end else begin
            req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      total_cnt++;
      if (recv != 38) $display("FAIL stream_count: got %0d expected 38", recv);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int k = 0;
      int n = 0;
      logic drop_next = 1'b0;
      rsp_ready = 1'b0;
      req_op = VADD; req_ww = 2'd3; req_shift = 5'd0; req_oprB = 64'h100;
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         req_oprA = 64'(k + 1); req_tag = 5'(k + 1);
         req_valid = 1'b1;
         if (req_ready) k++;
      end
      @(negedge clk);
      total_cnt++;
      if (k != 3) $display("FAIL bp_accepted: got %0d expected 3", k);
      else pass_cnt++;
      total_cnt++;
      if (req_ready !== 1'b0 || inflight !== 2'd3)
         $display("FAIL bp_stall: req_ready %b inflight %0d expected 0 3", req_ready, inflight);
      else pass_cnt++;
      req_oprA = 64'd4; req_tag = 5'd4;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
         if (drop_next) begin
            req_valid = 1'b0;
            drop_next = 1'b0;
         end
         if (req_valid && req_ready) drop_next = 1'b1;
         if (rsp_valid) begin
            total_cnt++;
            if (rsp_tag !== 5'(n + 1) || rsp_result !== 64'(n + 1 + 256))
               $display("FAIL bp_order_%0d: tag %0d result %h expected %0d %h", n, rsp_tag, rsp_result,
                        n + 1, 64'(n + 1 + 256));
            else pass_cnt++;
            $display("bp tag=%0d result=%h", rsp_tag, rsp_result);
            n++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      total_cnt++;
      if (n != 4) $display("FAIL bp_count: got %0d expected 4", n);
      else pass_cnt++;
   endtask

   task automatic test_illegal();
      logic got, err;
      logic [63:0] res;
      logic [4:0] tag;
      issue_and_wait(64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 5'd0, 6'd25, 2'd3, 5'd9, got, res, tag, err);
      total_cnt++;
      if (got !== 1'b1 || res !== 64'd0 || err !== 1'b1 || tag !== 5'd9)
         $display("FAIL illegal_op: valid %b result %h err %b tag %0d expected 1 0 1 9", got, res, err, tag);
      else pass_cnt++;
      issue_and_wait(64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 5'd0, VAND, 2'd3, 5'd10, got, res, tag, err);
      total_cnt++;
      if (got !== 1'b1 || res !== 64'd0 || err !== 1'b0 || tag !== 5'd10)
         $display("FAIL legal_after_illegal: valid %b result %h err %b tag %0d expected 1 0 0 10", got, res, err, tag);
      else pass_cnt++;
   endtask

   task automatic test_full_buffer();
      int n = 0;
      rsp_ready = 1'b0;
      req_op = VXOR; req_ww = 2'd3; req_shift = 5'd0; req_oprB = 64'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req_oprA = 64'(11 + i); req_tag = 5'(11 + i);
         req_valid = 1'b1;
         total_cnt++;
         if (req_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %b expected 1", i, req_ready);
         else pass_cnt++;
      end
      @(negedge clk);
      req_oprA = 64'd14; req_tag = 5'd14;
      total_cnt++;
      if (inflight !== 2'd3 || req_ready !== 1'b0)
         $display("FAIL full_state: inflight %0d req_ready %b expected 3 0", inflight, req_ready);
      else pass_cnt++;
      rsp_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if (inflight !== 2'd2 || rsp_valid !== 1'b1 || rsp_tag !== 5'd12 || req_ready !== 1'b1)
         $display("FAIL push_pop_full: inflight %0d valid %b tag %0d ready %b expected 2 1 12 1",
                  inflight, rsp_valid, rsp_tag, req_ready);
      else pass_cnt++;
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      total_cnt++;
      if (inflight !== 2'd3) $display("FAIL refill: inflight %0d expected 3", inflight);
      else pass_cnt++;
      rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 10 && n < 3; cyc++) begin
         if (rsp_valid) begin
            total_cnt++;
            if (rsp_tag !== 5'(12 + n) || rsp_result !== (64'(12 + n) ^ 64'hFF))
               $display("FAIL wrap_order_%0d: tag %0d result %h expected %0d %h", n, rsp_tag, rsp_result,
                        12 + n, 64'(12 + n) ^ 64'hFF);
            else pass_cnt++;
            $display("full tag=%0d result=%h", rsp_tag, rsp_result);
            n++;
         end
         @(negedge clk);
      end
      total_cnt++;
      if (n != 3 || inflight !== 2'd0)
         $display("FAIL wrap_drain: got %0d results inflight %0d expected 3 0", n, inflight);
      else pass_cnt++;
   endtask

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_accept_latency();
      test_lanes();
      test_streaming();
      test_backpressure();
      test_illegal();
      test_full_buffer();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
